// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential word fetch over req/ack, FIFO of {inst, pc+4}, redirect flush.
// Optional macro PREFETCH_BYPASS_EN: an ack into an empty FIFO is forwarded combinationally to the IF stage.
module inst_prefetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc_plus4,
   input  logic        inst_ready
);

   localparam int         PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc;
   logic [31:0]   req_addr;
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc4_mem  [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [PW:0]   count;
   logic          fifo_empty, fifo_full;
   logic          ack_in_req, push, pop;

   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == FULL);
   assign ack_in_req = (state == REQ) && mem_ack;

`ifdef PREFETCH_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit = fifo_empty && ack_in_req && !redirect_valid;
   // A forwarded word the consumer takes right away never enters the FIFO.
   assign push = ack_in_req && !redirect_valid && !(bypass_hit && inst_ready);
`else
   assign push = ack_in_req && !redirect_valid;
`endif
   assign pop = !fifo_empty && inst_ready && !redirect_valid;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
      state_next = state;
      case (state)
         IDLE:    if (!redirect_valid && !fifo_full) state_next = REQ;
         REQ:     if (mem_ack)             state_next = IDLE;
                  else if (redirect_valid) state_next = DROP;
         DROP:    if (mem_ack)             state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mem_req  = (state != IDLE);
      mem_addr = req_addr;
   end

   // The request address is captured at issue so it stays stable even if a redirect moves fetch_pc.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc <= RESET_PC;
         req_addr <= RESET_PC;
      end else begin
         if (redirect_valid)  fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
         else if (ack_in_req) fetch_pc <= fetch_pc + 32'd4;
         if (state == IDLE && state_next == REQ) req_addr <= fetch_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW + 1)'(1);
            2'b01:   count <= count - (PW + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // NOTE: the storage array has no reset; validity comes from count and outputs are gated by it.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= mem_rdata;
         pc4_mem[wr_ptr]  <= req_addr + 32'd4;
      end
   end

   always_comb begin
      inst_valid    = !fifo_empty;
      inst_data     = 32'h0;
      inst_pc_plus4 = 32'h0;
      if (!fifo_empty) begin
         inst_data     = data_mem[rd_ptr];
         inst_pc_plus4 = pc4_mem[rd_ptr];
      end
`ifdef PREFETCH_BYPASS_EN
      else if (bypass_hit) begin
         inst_valid    = 1'b1;
         inst_data     = mem_rdata;
         inst_pc_plus4 = req_addr + 32'd4;
      end
`endif
   end

endmodule
